// File: rtl/param_select_mux.sv
// param_select_mux: registered N-lane select stage with explicit or round-robin
// lane choice behind a valid/ready output register.
module param_select_mux #(
    parameter int WIDTH = 4,
    parameter int CHANNELS = 2,
    localparam int SEL_W = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] In,
    input  logic [SEL_W-1:0]          S,
    input  logic                      Mode,
    input  logic                      In_valid,
    output logic                      In_ready,
    output logic [WIDTH-1:0]          Out,
    output logic [SEL_W-1:0]          Sel_out,
    output logic                      Out_valid,
    input  logic                      Out_ready
);
    logic [SEL_W-1:0] rr_ptr, rr_next, sel;
    logic [WIDTH-1:0] lane;
    logic             accept;

    assign In_ready = !Out_valid || Out_ready;
    assign accept   = In_valid && In_ready;
    assign sel      = Mode ? rr_ptr : S;
    assign rr_next  = (int'(rr_ptr) == CHANNELS - 1) ? '0 : rr_ptr + 1'b1;

    // Selects past the last lane exist only for non-power-of-2 lane counts.
    always_comb lane = (int'(sel) < CHANNELS) ? In[int'(sel)*WIDTH +: WIDTH] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Out       <= '0;
            Sel_out   <= '0;
            Out_valid <= 1'b0;
            rr_ptr    <= '0;
        end else if (accept) begin
            Out       <= lane;
            Sel_out   <= sel;
            Out_valid <= 1'b1;
            if (Mode) rr_ptr <= rr_next;
        end else if (Out_ready) begin
            Out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_param_select_mux.sv
// tb_param_select_mux: vector table plus scoreboard checks for 2-, 3- and 4-lane
// instances of param_select_mux sharing one control stream.
module tb_param_select_mux;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [1:0]  s = '0;
    logic [7:0]  in2 = 8'hBA;
    logic [11:0] in3 = 12'hCBA;
    logic [15:0] in4 = 16'hDCBA;

    logic       r2, r3, r4, v2, v3, v4;
    logic [3:0] o2, o3, o4;
    logic       sl2;
    logic [1:0] sl3, sl4;

    int checks = 0, errors = 0;
    logic [5:0] q[$];
    logic [1:0] rr_m = '0;

    always #5 clk = ~clk;

    param_select_mux #(.WIDTH(4), .CHANNELS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .In(in2), .S(s[0]), .Mode(mode), .In_valid(in_valid),
        .In_ready(r2), .Out(o2), .Sel_out(sl2), .Out_valid(v2), .Out_ready(out_ready));
    param_select_mux #(.WIDTH(4), .CHANNELS(3)) u3 (
        .clk(clk), .rst_n(rst_n), .In(in3), .S(s), .Mode(mode), .In_valid(in_valid),
        .In_ready(r3), .Out(o3), .Sel_out(sl3), .Out_valid(v3), .Out_ready(out_ready));
    param_select_mux #(.WIDTH(4), .CHANNELS(4)) u4 (
        .clk(clk), .rst_n(rst_n), .In(in4), .S(s), .Mode(mode), .In_valid(in_valid),
        .In_ready(r4), .Out(o4), .Sel_out(sl4), .Out_valid(v4), .Out_ready(out_ready));

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives one cycle, updates the 4-lane scoreboard at the edge, checks at the next negedge.
    task automatic step(input logic v, input logic m, input logic [1:0] sv, input logic ordy);
        logic       rdy_m;
        logic [1:0] sel_m;
        logic [3:0] tmp;
        in_valid = v; mode = m; s = sv; out_ready = ordy;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            rr_m = '0;
        end else begin
            rdy_m = (q.size() == 0) || out_ready;
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (in_valid && rdy_m) begin
                sel_m = mode ? rr_m : s;
                case (sel_m)
                    2'd0: tmp = in4[3:0];
                    2'd1: tmp = in4[7:4];
                    2'd2: tmp = in4[11:8];
                    default: tmp = in4[15:12];
                endcase
                q.push_back({tmp, sel_m});
                if (mode) rr_m = (rr_m == 2'd3) ? 2'd0 : rr_m + 2'd1;
            end
        end
        @(negedge clk);
        chk("u4_valid", {7'd0, v4}, {7'd0, q.size() != 0});
        chk("u4_in_ready", {7'd0, r4}, {7'd0, (q.size() == 0) || out_ready});
        if (q.size() != 0) begin
            chk("u4_out", {4'd0, o4}, {4'd0, q[0][5:2]});
            chk("u4_sel", {6'd0, sl4}, {6'd0, q[0][1:0]});
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, 1'b0, 2'd0, 1'b1);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       v, m;
        logic [1:0] s;
        logic       ordy;
        logic       ev;
        logic [3:0] eo;
        logic       es;
    } vec_t;

    vec_t tbl[11];
    logic [3:0] rr_seq[6];

    initial begin
        tbl = '{
            '{1, 0, 0, 1, 1, 4'hA, 0}, '{1, 0, 1, 1, 1, 4'hB, 1}, '{0, 0, 0, 1, 0, 4'hB, 1},
            '{1, 1, 0, 1, 1, 4'hA, 0}, '{1, 1, 1, 1, 1, 4'hB, 1}, '{1, 1, 0, 1, 1, 4'hA, 0},
            '{1, 0, 1, 0, 1, 4'hA, 0}, '{1, 0, 1, 0, 1, 4'hA, 0}, '{1, 0, 1, 1, 1, 4'hB, 1},
            '{0, 0, 0, 0, 1, 4'hB, 1}, '{0, 0, 0, 1, 0, 4'hB, 1}};
        rr_seq = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA, 4'hB};

        do_reset();
        chk("rst_out", {4'd0, o2}, 8'h00);
        chk("rst_sel", {7'd0, sl2}, 8'h00);
        chk("rst_valid", {7'd0, v2}, 8'h00);
        chk("rst_ready", {7'd0, r2}, 8'h01);

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].v, tbl[i].m, tbl[i].s, tbl[i].ordy);
            chk($sformatf("u2_valid[%0d]", i), {7'd0, v2}, {7'd0, tbl[i].ev});
            chk($sformatf("u2_out[%0d]", i), {4'd0, o2}, {4'd0, tbl[i].eo});
            chk($sformatf("u2_sel[%0d]", i), {7'd0, sl2}, {7'd0, tbl[i].es});
        end

        // Round-robin wrap across 4 lanes; S must be ignored.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 2'($urandom_range(3)), 1'b1);
            chk($sformatf("rr_out[%0d]", i), {4'd0, o4}, {4'd0, rr_seq[i]});
        end

        // Backpressure holds the word while In changes underneath.
        do_reset();
        step(1'b1, 1'b0, 2'd1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            in4 = 16'($urandom);
            step(1'b1, 1'b0, 2'd2, 1'b0);
            chk("bp_hold", {4'd0, o4}, 8'h0B);
            chk("bp_ready", {7'd0, r4}, 8'h00);
        end
        in4 = 16'h9876;
        step(1'b1, 1'b0, 2'd2, 1'b1);
        chk("bp_release", {4'd0, o4}, 8'h08);
        in4 = 16'hDCBA;

        // Pointer survives explicit-mode traffic.
        do_reset();
        step(1'b1, 1'b1, 2'd0, 1'b1);
        step(1'b1, 1'b1, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd3, 1'b1);
        step(1'b1, 1'b1, 2'd0, 1'b1);
        chk("rr_resume_sel", {6'd0, sl4}, 8'h02);
        chk("rr_resume_out", {4'd0, o4}, 8'h0C);

        // Out-of-range select on the 3-lane instance.
        do_reset();
        step(1'b1, 1'b0, 2'd3, 1'b1);
        chk("oor_out", {4'd0, o3}, 8'h00);
        chk("oor_sel", {6'd0, sl3}, 8'h03);
        chk("oor_valid", {7'd0, v3}, 8'h01);
        step(1'b1, 1'b0, 2'd2, 1'b1);
        chk("c3_lane2", {4'd0, o3}, 8'h0C);

        // Reset while a word is stalled.
        do_reset();
        step(1'b1, 1'b0, 2'd1, 1'b1);
        step(1'b0, 1'b0, 2'd0, 1'b0);
        chk("stall_valid", {7'd0, v4}, 8'h01);
        rst_n = 1'b0;
        step(1'b1, 1'b0, 2'd2, 1'b0);
        rst_n = 1'b1;
        chk("mid_rst_out", {4'd0, o4}, 8'h00);
        chk("mid_rst_sel", {6'd0, sl4}, 8'h00);
        chk("mid_rst_valid", {7'd0, v4}, 8'h00);
        chk("mid_rst_ready", {7'd0, r4}, 8'h01);
        step(1'b1, 1'b1, 2'd3, 1'b1);
        chk("post_rst_rr_sel", {6'd0, sl4}, 8'h00);
        chk("post_rst_rr_out", {4'd0, o4}, 8'h0A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
